// File: rtl/bsg_gateway_reset_sequencer_if.sv
// Interface bundle for the gateway reset sequencer: lock/soft-reset inputs and
// the ordered domain resets plus status outputs.
interface bsg_gateway_reset_sequencer_if;
  logic       pll_locked_i;
  logic       soft_reset_i;
  logic       mb_reset_o;
  logic       io_reset_o;
  logic       core_reset_o;
  logic       ext_reset_o;
  logic       ready_o;
  logic [2:0] state_o;
  logic [7:0] lock_loss_count_o;

  modport slave (
    input  pll_locked_i,
    input  soft_reset_i,
    output mb_reset_o,
    output io_reset_o,
    output core_reset_o,
    output ext_reset_o,
    output ready_o,
    output state_o,
    output lock_loss_count_o
  );

  modport master (
    output pll_locked_i,
    output soft_reset_i,
    input  mb_reset_o,
    input  io_reset_o,
    input  core_reset_o,
    input  ext_reset_o,
    input  ready_o,
    input  state_o,
    input  lock_loss_count_o
  );
endinterface

// File: rtl/bsg_gateway_reset_sequencer.sv
// Gateway reset sequencer: waits for a stable PLL/DCM lock, then releases the
// microblaze, IO, core and off-board ASIC resets in order, re-sequencing on lock loss.
module bsg_gateway_reset_sequencer #(
  parameter int lock_stable_cycles_p = 1024,
  parameter int stage_gap_cycles_p   = 64
) (
  input logic clk_i,
  input logic reset_i,
  bsg_gateway_reset_sequencer_if.slave bus
);

  localparam int max_cycles_lp = (lock_stable_cycles_p > stage_gap_cycles_p)
                                 ? lock_stable_cycles_p : stage_gap_cycles_p;
  localparam int cnt_width_lp  = $clog2(max_cycles_lp) + 1;

  localparam logic [cnt_width_lp-1:0] stable_last_lp = cnt_width_lp'(lock_stable_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0] gap_last_lp    = cnt_width_lp'(stage_gap_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0] cnt_one_lp     = cnt_width_lp'(1);
  localparam logic [cnt_width_lp-1:0] cnt_zero_lp    = cnt_width_lp'(0);

  localparam logic [2:0] wait_lock_lp = 3'd0;
  localparam logic [2:0] stable_lp    = 3'd1;
  localparam logic [2:0] mb_up_lp     = 3'd2;
  localparam logic [2:0] io_up_lp     = 3'd3;
  localparam logic [2:0] core_up_lp   = 3'd4;
  localparam logic [2:0] run_lp       = 3'd5;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  logic                    sync1_r;
  logic                    lock_r;
  logic                    lock_s;
  logic [2:0]              state_r;
  logic [2:0]              state_n_s;
  logic [cnt_width_lp-1:0] cnt_r;
  logic [cnt_width_lp-1:0] cnt_n_s;
  logic [cnt_width_lp-1:0] stage_last_s;
  logic                    loss_s;
  logic [7:0]              loss_cnt_r;
  logic                    mb_n_s, io_n_s, core_n_s, ext_n_s, ready_n_s;
  logic                    mb_r, io_r, core_r, ext_r, ready_r;

  assign lock_s = lock_r;

  // Two-flop synchronizer for the asynchronous lock indication
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_r <= 1'b0;
      lock_r  <= 1'b0;
    end else begin
      sync1_r <= bus.pll_locked_i;
      lock_r  <= sync1_r;
    end
  end

  // State, dwell counter and lock-loss counter registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= wait_lock_lp;
      cnt_r      <= cnt_zero_lp;
      loss_cnt_r <= 8'd0;
    end else begin
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
      if (loss_s) begin
        loss_cnt_r <= sat_inc(loss_cnt_r);
      end else begin
        loss_cnt_r <= loss_cnt_r;
      end
    end
  end

  // Next-state and counter logic; lock loss outranks soft reset
  always_comb begin
    state_n_s    = state_r;
    cnt_n_s      = cnt_r;
    loss_s       = 1'b0;
    stage_last_s = (state_r == stable_lp) ? stable_last_lp : gap_last_lp;
    case (state_r)
      wait_lock_lp: begin
        cnt_n_s = cnt_zero_lp;
        if (lock_s) begin
          state_n_s = stable_lp;
        end else begin
          state_n_s = wait_lock_lp;
        end
      end
      stable_lp, mb_up_lp, io_up_lp, core_up_lp, run_lp: begin
        if (!lock_s) begin
          state_n_s = wait_lock_lp;
          cnt_n_s   = cnt_zero_lp;
          loss_s    = 1'b1;
        end else if (bus.soft_reset_i) begin
          state_n_s = stable_lp;
          cnt_n_s   = cnt_zero_lp;
        end else if (state_r == run_lp) begin
          state_n_s = run_lp;
          cnt_n_s   = cnt_zero_lp;
        end else if (cnt_r == stage_last_s) begin
          state_n_s = state_r + 3'd1;
          cnt_n_s   = cnt_zero_lp;
        end else begin
          state_n_s = state_r;
          cnt_n_s   = cnt_r + cnt_one_lp;
        end
      end
      default: begin
        state_n_s = wait_lock_lp;
        cnt_n_s   = cnt_zero_lp;
      end
    endcase
  end

  // Reset/ready values decoded from the upcoming state so they move with it
  always_comb begin
    mb_n_s    = 1'b1;
    io_n_s    = 1'b1;
    core_n_s  = 1'b1;
    ext_n_s   = 1'b1;
    ready_n_s = 1'b0;
    case (state_n_s)
      wait_lock_lp, stable_lp: begin
        mb_n_s = 1'b1;
      end
      mb_up_lp: begin
        mb_n_s = 1'b0;
      end
      io_up_lp: begin
        mb_n_s = 1'b0;
        io_n_s = 1'b0;
      end
      core_up_lp: begin
        mb_n_s   = 1'b0;
        io_n_s   = 1'b0;
        core_n_s = 1'b0;
      end
      run_lp: begin
        mb_n_s    = 1'b0;
        io_n_s    = 1'b0;
        core_n_s  = 1'b0;
        ext_n_s   = 1'b0;
        ready_n_s = 1'b1;
      end
      default: begin
        mb_n_s    = 1'b1;
        io_n_s    = 1'b1;
        core_n_s  = 1'b1;
        ext_n_s   = 1'b1;
        ready_n_s = 1'b0;
      end
    endcase
  end

  // Registered reset and ready outputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mb_r    <= 1'b1;
      io_r    <= 1'b1;
      core_r  <= 1'b1;
      ext_r   <= 1'b1;
      ready_r <= 1'b0;
    end else begin
      mb_r    <= mb_n_s;
      io_r    <= io_n_s;
      core_r  <= core_n_s;
      ext_r   <= ext_n_s;
      ready_r <= ready_n_s;
    end
  end

  assign bus.mb_reset_o        = mb_r;
  assign bus.io_reset_o        = io_r;
  assign bus.core_reset_o      = core_r;
  assign bus.ext_reset_o       = ext_r;
  assign bus.ready_o           = ready_r;
  assign bus.state_o           = state_r;
  assign bus.lock_loss_count_o = loss_cnt_r;

endmodule

// File: tb/tb_bsg_gateway_reset_sequencer.sv
// Scoreboard bench for the gateway reset sequencer: a phase-based reference model
// predicts each cycle's outputs, and a monitor compares them after every edge.
module tb_bsg_gateway_reset_sequencer;
  localparam int S = 16;
  localparam int G = 4;

  typedef struct packed {
    logic       mb;
    logic       io;
    logic       core;
    logic       ext;
    logic       ready;
    logic [2:0] st;
    logic [7:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bsg_gateway_reset_sequencer_if bus_if();

  bsg_gateway_reset_sequencer #(
    .lock_stable_cycles_p(S),
    .stage_gap_cycles_p (G)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus_if)
  );

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference: phase = edges since the last sequence start (-1 while waiting for lock)
  int   m_phase = -1;
  int   m_loss  = 0;
  bit   m_lock_q[$];

  function automatic void model_reset();
    m_phase  = -1;
    m_loss   = 0;
    m_lock_q = '{1'b0, 1'b0};
  endfunction

  function automatic void model_step(input bit lk, input bit sr, input bit r);
    bit ls;
    if (r) begin
      model_reset();
    end else begin
      ls = m_lock_q.pop_front();
      m_lock_q.push_back(lk);
      if (m_phase < 0) begin
        if (ls) m_phase = 0;
      end else if (!ls) begin
        m_phase = -1;
        if (m_loss < 255) m_loss++;
      end else if (sr) begin
        m_phase = 0;
      end else if (m_phase < S + 3 * G) begin
        m_phase++;
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    if (m_phase < 0)              e.st = 3'd0;
    else if (m_phase < S)         e.st = 3'd1;
    else if (m_phase < S + G)     e.st = 3'd2;
    else if (m_phase < S + 2 * G) e.st = 3'd3;
    else if (m_phase < S + 3 * G) e.st = 3'd4;
    else                          e.st = 3'd5;
    e.mb    = (m_phase < S);
    e.io    = (m_phase < S + G);
    e.core  = (m_phase < S + 2 * G);
    e.ext   = (m_phase < S + 3 * G);
    e.ready = (m_phase >= S + 3 * G);
    e.cnt   = m_loss[7:0];
    return e;
  endfunction

  function automatic exp_t dut_out();
    exp_t a;
    a.mb    = bus_if.mb_reset_o;
    a.io    = bus_if.io_reset_o;
    a.core  = bus_if.core_reset_o;
    a.ext   = bus_if.ext_reset_o;
    a.ready = bus_if.ready_o;
    a.st    = bus_if.state_o;
    a.cnt   = bus_if.lock_loss_count_o;
    return a;
  endfunction

  task automatic cycle(input bit lk, input bit sr, input bit r);
    @(negedge clk);
    rst = r;
    bus_if.pll_locked_i = lk;
    bus_if.soft_reset_i = sr;
    model_step(lk, sr, r);
    exp_q.push_back(model_out());
  endtask

  task automatic hold(input bit lk, input int n);
    for (int i = 0; i < n; i++) cycle(lk, 1'b0, 1'b0);
  endtask

  task automatic async_reset();
    exp_t a;
    exp_t e;
    @(negedge clk);
    bus_if.soft_reset_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    a = dut_out();
    e = '{mb: 1'b1, io: 1'b1, core: 1'b1, ext: 1'b1, ready: 1'b0, st: 3'd0, cnt: 8'd0};
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL async_reset t=%0t actual=%h required=%h", $time, a, e);
    end
    model_step(bus_if.pll_locked_i, 1'b0, 1'b1);
    exp_q.push_back(model_out());
  endtask

  // Monitor: every edge yields one output word to compare against the scoreboard
  initial begin : monitor
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = dut_out();
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL scoreboard t=%0t actual mb%b io%b core%b ext%b rdy%b st%0d cnt%0d required mb%b io%b core%b ext%b rdy%b st%0d cnt%0d",
                   $time, a.mb, a.io, a.core, a.ext, a.ready, a.st, a.cnt,
                   e.mb, e.io, e.core, e.ext, e.ready, e.st, e.cnt);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    fails++;
    $display("FAIL watchdog: run did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : stim
    bus_if.pll_locked_i = 1'b0;
    bus_if.soft_reset_i = 1'b0;
    model_reset();
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);

    // Basic power-up sequence
    hold(1'b0, 3);
    hold(1'b1, 3 + S + 3 * G + 5);

    // Lock drop while in STABLE, then restore
    cycle(1'b0, 1'b0, 1'b1);
    hold(1'b0, 2);
    hold(1'b1, 12);
    hold(1'b0, 5);
    hold(1'b1, 3 + S + 3 * G + 5);

    // Soft reset from RUN
    cycle(1'b1, 1'b1, 1'b0);
    hold(1'b1, S + 3 * G + 4);

    // Soft reset coinciding with lock_s falling in IO_UP
    cycle(1'b1, 1'b1, 1'b0);
    hold(1'b1, S + 3);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    hold(1'b1, 3 + S + 3 * G + 3);

    // Repeated one-cycle drops in RUN drive the loss counter into saturation
    for (int k = 0; k < 300; k++) begin
      hold(1'b0, 1);
      hold(1'b1, 2 + S + 3 * G + 3);
    end

    // Asynchronous reset while in CORE_UP
    cycle(1'b1, 1'b1, 1'b0);
    hold(1'b1, S + 2 * G + 1);
    async_reset();
    cycle(1'b1, 1'b0, 1'b1);
    hold(1'b1, 3 + S + 3 * G + 3);

    // Randomized lock and soft-reset traffic
    for (int k = 0; k < 600; k++) begin
      cycle(($urandom_range(0, 19) != 0), ($urandom_range(0, 24) == 0), 1'b0);
    end
    hold(1'b1, 3 + S + 3 * G + 3);

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
